// File: rtl/dt_line_ctl_if.sv
// Line-level handshake between the tape controller core and dt_line_ctl.
// The write side carries 3-bit lines into the controller's buffer.
// The read side returns decoded 4-bit lines as single-cycle strobes.
interface dt_line_ctl_if;
  logic [2:0] wl_data;
  logic       wl_valid;
  logic       wl_ready;
  logic [3:0] rl_data;
  logic       rl_valid;

  // Controller core side
  modport master (
    output wl_data, wl_valid,
    input  wl_ready, rl_data, rl_valid
  );

  // Line controller side
  modport slave (
    input  wl_data, wl_valid,
    output wl_ready, rl_data, rl_valid
  );
endinterface

// File: rtl/dt_line_ctl.sv
// DECtape controller line interface toward tu56.
// Write side: builds the 5-track write flux from buffered 3-bit lines.
// In WRTM mode the timing track comes from an internal 2-bit TCK counter.
// Read side: decodes synchronized read flux into 4-bit line strobes.
// TP0 and TP1 are derived either from TCK (wrtm=1) or from edges of the
// synchronized timing track (wrtm=0).
module dt_line_ctl #(
  parameter int SYNC       = 2,
  parameter int WBUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clk_en,
  input  logic         wrtm,
  input  logic         wr,
  input  logic         con_wrtm_wait,
  output logic [4:0]   con_write,
  input  logic [4:0]   con_read,
  dt_line_ctl_if.slave line_if,
  output logic         underrun,
  output logic         tp0,
  output logic         tp1
);

  localparam int AW = $clog2(WBUF_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(WBUF_DEPTH);

  // tck_q[1] is the counter MSB, which drives the timing track.
  logic [1:0]            tck_q, tck_d;
  logic                  dec_q, dec_d;
  logic                  tp0_q, tp0_d;
  logic                  tp1_q, tp1_d;
  logic [SYNC-1:0][4:0]  sync_q;
  logic                  tim_prev_q;
  logic [4:0]            rd_sync;
  logic [2:0]            line_q, line_d;
  logic [2:0]            mem_q [WBUF_DEPTH];
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  wl_ready_q, wl_ready_d;
  logic [3:0]            rl_data_q, rl_data_d;
  logic                  rl_valid_q, rl_valid_d;
  logic                  underrun_q, underrun_d;
  logic                  tck_dec, empty, push, pop;

  assign rd_sync = sync_q[SYNC-1];
  assign empty   = (count_q == '0);
  assign push    = line_if.wl_valid & wl_ready_q;
  assign pop     = tp0_q & wr & ~empty;
  assign tck_dec = wrtm & clk_en & ~con_wrtm_wait;

  // TCK counter and TP0/TP1 generation from either source
  always_comb begin
    tck_d = tck_q;
    dec_d = tck_dec;
    tp0_d = 1'b0;
    tp1_d = 1'b0;
    if (!wrtm) begin
      tck_d = 2'b00;
    end else if (tck_dec) begin
      tck_d = tck_q - 2'd1;
    end
    if (wrtm) begin
      // Fires only after a real decrement, so the forced return to 0 on
      // leaving WRTM cannot produce a strobe.
      tp1_d = dec_q & (tck_q == 2'b10);
      tp0_d = dec_q & (tck_q == 2'b00);
    end else begin
      tp1_d = rd_sync[0] & ~tim_prev_q;
      tp0_d = ~rd_sync[0] & tim_prev_q;
    end
  end

  // Write line register, buffer bookkeeping and read capture
  always_comb begin
    line_d     = line_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    underrun_d = underrun_q;
    rl_data_d  = rl_data_q;
    rl_valid_d = 1'b0;
    if (wr && tp0_q) begin
      if (empty) begin
        line_d     = 3'b000;
        underrun_d = 1'b1;
      end else begin
        line_d = mem_q[rd_ptr_q];
      end
    end else if (wr && tp1_q) begin
      line_d = ~line_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
    wl_ready_d = (count_d != FULL_CNT);
    if (tp1_d && !wr) begin
      rl_data_d  = rd_sync[4:1];
      rl_valid_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tck_q      <= 2'b00;
      dec_q      <= 1'b0;
      tp0_q      <= 1'b0;
      tp1_q      <= 1'b0;
      sync_q     <= '0;
      tim_prev_q <= 1'b0;
      line_q     <= 3'b000;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      wl_ready_q <= 1'b1;
      rl_data_q  <= 4'h0;
      rl_valid_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      tck_q      <= tck_d;
      dec_q      <= dec_d;
      tp0_q      <= tp0_d;
      tp1_q      <= tp1_d;
      sync_q[0]  <= con_read;
      for (int i = 1; i < SYNC; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      tim_prev_q <= rd_sync[0];
      line_q     <= line_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      wl_ready_q <= wl_ready_d;
      rl_data_q  <= rl_data_d;
      rl_valid_q <= rl_valid_d;
      underrun_q <= underrun_d;
    end
  end

  // Buffer storage; contents are don't-care once the pointers reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= line_if.wl_data;
    end
  end

  // Track mapping: [0] timing, [1] mark copy of line[0], [4:2] line
  always_comb begin
    con_write[0]   = tck_q[1];
    con_write[1]   = line_q[0];
    con_write[4:2] = line_q;
  end

  assign line_if.wl_ready = wl_ready_q;
  assign line_if.rl_data  = rl_data_q;
  assign line_if.rl_valid = rl_valid_q;
  assign underrun         = underrun_q;
  assign tp0              = tp0_q;
  assign tp1              = tp1_q;

endmodule

// File: tb/tb_dt_line_ctl.sv
// Self-checking bench for dt_line_ctl: TCK timing, stall, buffered write
// stream with underrun/full, reset mid-write, WRTM exit and read decode.
module tb_dt_line_ctl;
  localparam int SYNC  = 2;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       reset, clk_en, wrtm, wr, con_wrtm_wait;
  logic [4:0] con_write, con_read;
  logic       underrun, tp0, tp1;

  dt_line_ctl_if bus ();

  dt_line_ctl #(.SYNC(SYNC), .WBUF_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .clk_en        (clk_en),
    .wrtm          (wrtm),
    .wr            (wr),
    .con_wrtm_wait (con_wrtm_wait),
    .con_write     (con_write),
    .con_read      (con_read),
    .line_if       (bus),
    .underrun      (underrun),
    .tp0           (tp0),
    .tp1           (tp1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [2:0] wq[$];
  logic [3:0] rq[$];
  logic [2:0] line_m;
  bit         und_m;
  int         tck_m;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Read scoreboard: every rl_valid pulse must match the next queued line
  always @(negedge clk) begin
    if (bus.rl_valid === 1'b1) begin
      if (rq.size() > 0) check_eq("rl_data", bus.rl_data, rq.pop_front());
      else               check_eq("rl_extra", bus.rl_valid, 1'b0);
    end
  end

  task automatic model_reset();
    wq.delete();
    line_m = 3'b000;
    und_m  = 1'b0;
    tck_m  = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_eq("rst_con_write", con_write, 5'b0);
    check_eq("rst_wl_ready", bus.wl_ready, 1'b1);
    check_eq("rst_underrun", underrun, 1'b0);
    check_eq("rst_rl_valid", bus.rl_valid, 1'b0);
    check_eq("rst_tp", {tp0, tp1}, 2'b00);
  endtask

  task automatic push(input logic [2:0] d);
    bit acc;
    acc = (wq.size() < DEPTH);
    check_eq("wl_ready", bus.wl_ready, acc);
    if (acc) wq.push_back(d);
    bus.wl_data  = d;
    bus.wl_valid = 1'b1;
    @(negedge clk);
    bus.wl_valid = 1'b0;
  endtask

  // One clk_en tick; con_wrtm_wait decides whether TCK should move.
  // Returns whether a TP0 was expected.
  task automatic tick(output bit was_tp0);
    int old;
    bit e0, e1, run;
    old = tck_m;
    run = wrtm && !con_wrtm_wait;
    clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
    if (run) tck_m = (tck_m + 3) % 4;
    e1 = run && (old == 3);
    e0 = run && (old == 1);
    was_tp0 = e0;
    check_eq("tck_msb", con_write[0], tck_m >= 2);
    check_eq("tp_early", {tp0, tp1}, 2'b00);
    @(negedge clk);
    check_eq("tp0", tp0, e0);
    check_eq("tp1", tp1, e1);
    @(negedge clk);
    if (wr) begin
      if (e0) begin
        if (wq.size() > 0) line_m = wq.pop_front();
        else begin line_m = 3'b000; und_m = 1'b1; end
      end else if (e1) begin
        line_m = ~line_m;
      end
    end
    check_eq("line", con_write[4:2], line_m);
    check_eq("mark", con_write[1], line_m[0]);
    check_eq("underrun", underrun, und_m);
    @(negedge clk);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit t0;
    int k;
    logic [2:0] wlines [4];
    logic [3:0] rlines [4];
    int nxt;
    wlines = '{3'b110, 3'b010, 3'b010, 3'b110};
    rlines = '{4'b1111, 4'b1001, 4'b0001, 4'b0111};

    reset = 1'b1; clk_en = 1'b0; wrtm = 1'b0; wr = 1'b0; con_wrtm_wait = 1'b0;
    con_read = 5'b0; bus.wl_data = 3'b0; bus.wl_valid = 1'b0;
    repeat (3) @(negedge clk);
    apply_reset();

    // TCK sequence 3,2,1,0 with an empty buffer (underrun on first TP0)
    wrtm = 1'b1; wr = 1'b1;
    repeat (4) tick(t0);
    // Stall: TCK frozen for 10 ticks, then resumes from the same value
    repeat (1) tick(t0);
    con_wrtm_wait = 1'b1;
    repeat (10) tick(t0);
    con_wrtm_wait = 1'b0;
    repeat (4) tick(t0);

    // Write stream with full check and final underrun
    apply_reset();
    push(wlines[0]);
    push(wlines[1]);
    push(3'b111);
    nxt = 2;
    for (int i = 0; i < 20; i++) begin
      tick(t0);
      if (t0 && nxt < 4) begin
        push(wlines[nxt]);
        nxt++;
      end
    end

    // Reset while one entry is buffered and line=101
    apply_reset();
    push(3'b101);
    push(3'b011);
    repeat (4) tick(t0);
    check_eq("line_101", con_write[4:2], 3'b101);
    apply_reset();
    repeat (4) tick(t0);

    // Leaving WRTM mid-line: TCK back to 0, no strobes
    tick(t0);
    wrtm = 1'b0;
    @(negedge clk);
    tck_m = 0;
    check_eq("wrtm_exit_tck", con_write[0], 1'b0);
    repeat (3) begin
      @(negedge clk);
      check_eq("wrtm_exit_tp", {tp0, tp1}, 2'b00);
    end

    // Read decode
    wr = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      con_read = {rlines[i], 1'b0};
      repeat (3) @(negedge clk);
      rq.push_back(rlines[i]);
      con_read[0] = 1'b1;
      k = 0;
      for (int j = 1; j <= 10; j++) begin
        @(negedge clk);
        if (bus.rl_valid === 1'b1) begin k = j; break; end
      end
      check_eq("rl_latency", k, SYNC + 1);
      repeat (3) @(negedge clk);
      con_read[0] = 1'b0;
      repeat (5) @(negedge clk);
    end
    check_eq("rl_missing", rq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
